// File: rtl/wave_dac_driver_pkg.sv
// Shared encodings for the waveform DAC driver: wave selects, FSM states, frame size.
package wave_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int FRAME_BITS = 16;

    localparam logic [1:0] WAVE_SAW    = 2'b00;
    localparam logic [1:0] WAVE_RAMPDN = 2'b01;
    localparam logic [1:0] WAVE_TRI    = 2'b10;
    localparam logic [1:0] WAVE_SQR    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/wave_dac_driver_if.sv
// Counter-side inputs and serial DAC outputs of the waveform DAC driver.
// master = phase source / DAC pins observer, slave = the driver itself.
interface wave_dac_if;
    import wave_pkg::*;

    logic [SAMPLE_W-1:0] addr;
    logic [1:0]          wave_sel;
    logic                enable;
    logic [SAMPLE_W-1:0] sample_out;
    logic                dac_cs_n;
    logic                dac_sclk;
    logic                dac_din;
    logic                busy;
    logic                frame_done;

    modport master (
        output addr, wave_sel, enable,
        input  sample_out, dac_cs_n, dac_sclk, dac_din, busy, frame_done
    );

    modport slave (
        input  addr, wave_sel, enable,
        output sample_out, dac_cs_n, dac_sclk, dac_din, busy, frame_done
    );

endinterface

// File: rtl/wave_shaper.sv
// Combinational phase-to-amplitude mapping: saw, ramp-down, triangle, square.
// Zero latency; no flow control.
module wave_shaper
    import wave_pkg::*;
(
    input  logic [SAMPLE_W-1:0] i_addr,
    input  logic [1:0]          i_sel,
    output logic [SAMPLE_W-1:0] o_sample
);

    always_comb begin
        o_sample = i_addr;
        case (i_sel)
            WAVE_SAW:    o_sample = i_addr;
            WAVE_RAMPDN: o_sample = ~i_addr;
            // Doubling the low 7 bits folds the second half back down.
            WAVE_TRI:    o_sample = i_addr[7] ? ~{i_addr[6:0], 1'b0} : {i_addr[6:0], 1'b0};
            WAVE_SQR:    o_sample = {SAMPLE_W{i_addr[7]}};
            default:     o_sample = i_addr;
        endcase
    end

endmodule

// File: rtl/wave_dac_driver.sv
// Captures addr when idle and enabled, shifts {HDR, sample, 0000} MSB-first to a serial DAC.
// Frame = 1 capture + 32*SCLK_DIV shift + CS_HOLD hold cycles; inputs ignored while a frame is in flight.
module wave_dac_driver
    import wave_pkg::*;
#(
    parameter int         SCLK_DIV = 4,
    parameter int         CS_HOLD  = 4,
    parameter logic [3:0] HDR      = 4'h3
) (
    input  logic       clk,
    input  logic       reset,
    wave_dac_if.slave  bus
);

    localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    localparam int BIT_W  = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    state_t                r_state;
    logic [DIV_W-1:0]      r_div;
    logic [HOLD_W-1:0]     r_hold;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_phase;
    logic [FRAME_BITS-1:0] r_shift;
    logic [SAMPLE_W-1:0]   r_sample;
    logic                  r_cs_n;
    logic                  r_sclk;
    logic                  r_din;
    logic                  r_busy;
    logic                  r_done;

    logic [SAMPLE_W-1:0]   w_sample;
    logic [FRAME_BITS-1:0] w_frame;

    wave_shaper u_shaper (
        .i_addr   (bus.addr),
        .i_sel    (bus.wave_sel),
        .o_sample (w_sample)
    );

    assign w_frame = {HDR, w_sample, 4'b0000};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_hold   <= '0;
            r_bit    <= '0;
            r_phase  <= 1'b0;
            r_shift  <= '0;
            r_sample <= '0;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b0;
            r_din    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.enable) begin
                        r_state  <= SHIFT;
                        r_sample <= w_sample;
                        r_shift  <= w_frame;
                        r_din    <= w_frame[FRAME_BITS-1];
                        r_cs_n   <= 1'b0;
                        r_sclk   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_div    <= '0;
                        r_bit    <= '0;
                        r_phase  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + DIV_W'(1);
                    end else begin
                        r_div <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            r_sclk  <= 1'b1;
                        end else if (r_bit == BIT_LAST) begin
                            r_state <= HOLD;
                            r_phase <= 1'b0;
                            r_cs_n  <= 1'b1;
                            r_sclk  <= 1'b0;
                            r_din   <= 1'b0;
                            r_hold  <= '0;
                            r_done  <= (HOLD_LAST == '0);
                        end else begin
                            // Data only moves at the start of a low phase, so it is settled by the rising edge.
                            r_bit   <= r_bit + BIT_W'(1);
                            r_phase <= 1'b0;
                            r_sclk  <= 1'b0;
                            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                            r_din   <= r_shift[FRAME_BITS-2];
                        end
                    end
                end
                HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                        r_done <= ((r_hold + HOLD_W'(1)) == HOLD_LAST);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sample_out = r_sample;
    assign bus.dac_cs_n   = r_cs_n;
    assign bus.dac_sclk   = r_sclk;
    assign bus.dac_din    = r_din;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

endmodule

// File: doc/wave_dac_driver.md
Name: wave_dac_driver

Overview:
- Downstream of the waveform address counter: takes its 8-bit phase address `addr` each conversion.
- Shapes `addr` into an 8-bit sample (sawtooth, ramp-down, triangle or square).
- Shifts the sample out to an external serial DAC as a 16-bit frame, using chip-select, serial clock and data lines.
- Conversions run back-to-back while enabled, so the output sample rate is fixed by the frame timing, independent of the counter's step size.

Parameters:
- SCLK_DIV, 4: clk cycles per half-period of dac_sclk; legal range >= 1.
- CS_HOLD, 4: clk cycles dac_cs_n stays high after a frame before the next capture; legal range >= 1.
- HDR, 4'h3: 4-bit control header sent ahead of the sample in every frame.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  8  phase address from the counter.
- wave_sel  input  2  waveform select: 00 saw, 01 ramp-down, 10 triangle, 11 square.
- enable  input  1  allows a new conversion to start from IDLE.
- sample_out  output  8  sample of the frame in flight, registered.
- dac_cs_n  output  1  DAC chip select, active low.
- dac_sclk  output  1  DAC serial clock; the DAC samples dac_din on its rising edge.
- dac_din  output  1  DAC serial data, MSB first.
- busy  output  1  high from the first cs_n-low cycle through the last HOLD cycle.
- frame_done  output  1  one-cycle pulse on the last HOLD cycle.

Behaviour:
- Reset values: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, frame_done=0, sample_out=0, state=IDLE.
- Reset mid-frame aborts the frame: all outputs take their reset values on the next cycle; no frame_done is issued.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - cs_n=1, sclk=0.
  - If enable=1 at cycle T: capture addr and wave_sel, register the shaped sample into sample_out and a 16-bit shift register {HDR, sample, 4'b0000}, and go to SHIFT at T+1.
  - If enable=0: stay in IDLE.
- Waveform mapping (8-bit, no overflow):
  - saw = addr.
  - ramp-down = ~addr.
  - triangle = addr[7] ? ~{addr[6:0],1'b0} : {addr[6:0],1'b0}.
  - square = addr[7] ? 8'hFF : 8'h00.
- SHIFT spans T+1 .. T+32*SCLK_DIV, with cs_n=0 throughout.
  - Each bit occupies 2*SCLK_DIV cycles: sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - dac_din changes only on the first cycle of a low phase, so it is stable across each rising edge.
  - Bit 15 is on dac_din at T+1.
  - After the 16th high phase: go to HOLD with cs_n=1, sclk=0, din=0.
- HOLD: lasts CS_HOLD cycles; frame_done=1 on the last of them; then IDLE.
- Frame period with enable held high: 1 + 32*SCLK_DIV + CS_HOLD cycles (133 at defaults).
- addr, wave_sel and enable changes during SHIFT/HOLD are ignored; deasserting enable mid-frame does not truncate the frame.
- sample_out holds its value until the next capture.
- The internal bit counter (0..15) and divider counter (0..SCLK_DIV-1) wrap cleanly; no glitch pulses appear on sclk or cs_n.

Decomposition:
- Shared package wave_pkg holds:
  - wave_sel encodings WAVE_SAW, WAVE_RAMPDN, WAVE_TRI, WAVE_SQR;
  - state enum {IDLE, SHIFT, HOLD};
  - FRAME_BITS=16 constant.
- One sub-module, wave_shaper: purely combinational addr + wave_sel -> 8-bit sample. It is instanced once, and reused by the on-screen preview path.

Test Plan:
- Reset mid-SHIFT (assert at bit 9):
  - next cycle: cs_n=1, sclk=0, din=0, busy=0, no frame_done;
  - with enable=1 afterwards, the next frame starts cleanly from bit 15.
- wave_sel=00, addr=8'hA5, enable pulse:
  - sample_out=8'hA5;
  - serial capture on sclk rising edges reads 16'h3A50;
  - cs_n low for exactly 128 cycles;
  - frame_done exactly 132 cycles after the capture cycle.
- Triangle boundaries, one frame each:
  - addr=8'h00 -> 8'h00;
  - addr=8'h7F -> 8'hFE;
  - addr=8'h80 -> 8'hFF;
  - addr=8'hFF -> 8'h01.
- Square and ramp-down:
  - addr=8'h7F, sel=11 -> 8'h00;
  - addr=8'h80, sel=11 -> 8'hFF;
  - addr=8'h00, sel=01 -> 8'hFF.
- enable held high, addr toggling every cycle:
  - captures occur exactly 133 cycles apart;
  - each frame carries the addr present on its capture cycle;
  - mid-frame addr changes do not alter dac_din.
- enable dropped at bit 4 of a frame:
  - frame completes all 16 bits and frame_done pulses;
  - block then idles with cs_n=1 and busy=0 until enable returns.
